// File: rtl/song_scheduler.sv
// song_scheduler: sequences song loads for a shift/load note engine.
// It issues a one-cycle ld_song command and waits for the engine's finish edge.
// In loop mode it then inserts a gap and advances to the next song.
// A WAIT that sees no finish edge for TIMEOUT cycles is abandoned and flagged.
//
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous active-high reset
//   start       - request to play song_sel (accepted only in IDLE)
//   song_sel    - requested song, 1..3 valid, 0 ignored
//   loop_all    - sampled at each finish: 1 = continue with the next song
//   abort       - return to IDLE immediately from any active state
//   ld_finish   - finish level from the note engine (rising edge = finish)
//   ld_song     - song command, nonzero for exactly one cycle per load
//   busy        - high in every state except IDLE
//   cur_song    - song currently playing, 0 when none
//   song_done   - one-cycle pulse per completed song
//   timeout_err - sticky hang flag, cleared by rst or an accepted start
module song_scheduler #(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] song_sel,
  input  logic       loop_all,
  input  logic       abort,
  input  logic       ld_finish,
  output logic [1:0] ld_song,
  output logic       busy,
  output logic [1:0] cur_song,
  output logic       song_done,
  output logic       timeout_err
);

  // One counter is shared by WAIT and GAP, so it is sized for the larger limit.
  localparam int unsigned CNT_MAX = ((TIMEOUT - 1) > GAP_CYCLES) ? (TIMEOUT - 1) : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fin_prev_q;
  logic [1:0]       ld_song_q;
  logic             busy_q;
  logic [1:0]       cur_song_q;
  logic             song_done_q;
  logic             timeout_err_q;

  // A held-high finish level counts once: only its rising edge is an event.
  logic finish_evt;
  assign finish_evt = ld_finish & ~fin_prev_q;

  // Successor song in loop mode: 1 -> 2 -> 3 -> 1, never 0.
  logic [1:0] next_song;
  always_comb begin
    next_song = 2'd1;
    case (cur_song_q)
      2'd1:    next_song = 2'd2;
      2'd2:    next_song = 2'd3;
      default: next_song = 2'd1;
    endcase
  end

  // State machine with registered outputs; counter cleared on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      fin_prev_q    <= 1'b0;
      ld_song_q     <= 2'd0;
      busy_q        <= 1'b0;
      cur_song_q    <= 2'd0;
      song_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      fin_prev_q  <= ld_finish;
      ld_song_q   <= 2'd0;
      song_done_q <= 1'b0;
      cnt_q       <= cnt_q + CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          // abort alongside start keeps the block idle
          if (start && (song_sel != 2'd0) && !abort) begin
            state_q       <= S_LOAD;
            cur_song_q    <= song_sel;
            ld_song_q     <= song_sel;
            busy_q        <= 1'b1;
            timeout_err_q <= 1'b0;
          end
        end

        S_LOAD: begin
          cnt_q <= '0;
          if (abort) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            cur_song_q <= 2'd0;
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            cur_song_q <= 2'd0;
          end else if (finish_evt) begin
            cnt_q       <= '0;
            song_done_q <= 1'b1;
            if (loop_all) begin
              state_q    <= S_GAP;
              cur_song_q <= next_song;
            end else begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              cur_song_q <= 2'd0;
            end
          end else if (cnt_q == WAIT_LAST) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            cur_song_q    <= 2'd0;
            timeout_err_q <= 1'b1;
          end
        end

        S_GAP: begin
          // The song_done cycle is followed by GAP_CYCLES idle cycles before LOAD.
          if (abort) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            cur_song_q <= 2'd0;
          end else if (cnt_q == GAP_LAST) begin
            state_q   <= S_LOAD;
            cnt_q     <= '0;
            ld_song_q <= cur_song_q;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          busy_q     <= 1'b0;
          cur_song_q <= 2'd0;
        end
      endcase
    end
  end

  assign ld_song     = ld_song_q;
  assign busy        = busy_q;
  assign cur_song    = cur_song_q;
  assign song_done   = song_done_q;
  assign timeout_err = timeout_err_q;

endmodule
